// File: rtl/led7_pkg.sv
// Shared types and segment constants for the 7-segment scan encoder.
// Segment codes are active-low, bit0 = a through bit6 = g.
package led7_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef struct packed {
    logic [3:0] nibble;
    logic       blank;
    logic       err;
  } digit_t;

  localparam digit_t DigitReset = '{nibble: 4'h0, blank: 1'b1, err: 1'b0};

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StCapture
  } cap_state_e;

endpackage

// File: rtl/led7_seg_encoder.sv
// Combinational decode of an active-low segment pattern back to a hex digit record.
// Unknown patterns flag err; the all-off pattern flags blank.
module led7_seg_encoder
  import led7_pkg::*;
(
  input  logic [6:0] seg_i,
  output digit_t     digit_o
);

  always_comb begin
    digit_o = '{nibble: 4'h0, blank: 1'b0, err: 1'b0};
    case (seg_i)
      SEG_0:     digit_o.nibble = 4'h0;
      SEG_1:     digit_o.nibble = 4'h1;
      SEG_2:     digit_o.nibble = 4'h2;
      SEG_3:     digit_o.nibble = 4'h3;
      SEG_4:     digit_o.nibble = 4'h4;
      SEG_5:     digit_o.nibble = 4'h5;
      SEG_6:     digit_o.nibble = 4'h6;
      SEG_7:     digit_o.nibble = 4'h7;
      SEG_8:     digit_o.nibble = 4'h8;
      SEG_9:     digit_o.nibble = 4'h9;
      SEG_A:     digit_o.nibble = 4'hA;
      SEG_B:     digit_o.nibble = 4'hB;
      SEG_C:     digit_o.nibble = 4'hC;
      SEG_D:     digit_o.nibble = 4'hD;
      SEG_E:     digit_o.nibble = 4'hE;
      SEG_F:     digit_o.nibble = 4'hF;
      SEG_BLANK: digit_o.blank  = 1'b1;
      default:   digit_o.err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/led7_scan_encoder.sv
// Reads back a multiplexed 7-segment display, debounces whole frames and publishes them
// over valid/ready. Define LED7_SCAN_TIMEOUT_EN to enable the scan_lost idle detector.
module led7_scan_encoder
  import led7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned SETTLE_CYC    = 16,
  parameter int unsigned STABLE_FRAMES = 2,
  parameter int unsigned TIMEOUT_CYC   = 65536
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  output logic [4*NUM_DIGITS-1:0] value_out,
  output logic [NUM_DIGITS-1:0]   blank_out,
  output logic [NUM_DIGITS-1:0]   err_out,
  output logic                    valid_out,
  input  logic                    ready_in,
  output logic                    scan_lost
);

  localparam int unsigned CntW   = $clog2(SETTLE_CYC);
  localparam int unsigned MatchW = $clog2(STABLE_FRAMES + 1);
  localparam logic [CntW-1:0]   SettleLast = CntW'(SETTLE_CYC - 1);
  localparam logic [MatchW-1:0] MatchMax   = MatchW'(STABLE_FRAMES);

  // Input synchronizers plus one extra stage used for change detection.
  logic [6:0]            seg_meta, seg_q, seg_prev;
  logic [NUM_DIGITS-1:0] an_meta, an_q, an_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_meta <= SEG_BLANK;
      seg_q    <= SEG_BLANK;
      seg_prev <= SEG_BLANK;
      an_meta  <= '1;
      an_q     <= '1;
      an_prev  <= '1;
    end else begin
      seg_meta <= seg_in;
      seg_q    <= seg_meta;
      seg_prev <= seg_q;
      an_meta  <= an_in;
      an_q     <= an_meta;
      an_prev  <= an_q;
    end
  end

  logic [NUM_DIGITS-1:0] an_sel;
  logic                  an_onehot, an_changed, seg_changed;

  assign an_sel      = ~an_q;
  assign an_onehot   = (an_sel != '0) && ((an_sel & (an_sel - NUM_DIGITS'(1))) == '0);
  assign an_changed  = (an_q != an_prev);
  assign seg_changed = (seg_q != seg_prev);

  // Capture FSM
  cap_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            hold_q, hold_d;
  logic            capture;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    capture = 1'b0;
    if (an_changed) hold_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        // hold_q blocks re-capturing the same digit until the select moves on.
        if (an_onehot && (!hold_q || an_changed)) begin
          cnt_d   = '0;
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (an_changed || seg_changed || !an_onehot) begin
          state_d = StIdle;
        end else if (cnt_q == SettleLast) begin
          state_d = StCapture;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StCapture: begin
        capture = 1'b1;
        hold_d  = !an_changed;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

  // Encode the *_prev copies: those are the values the last SETTLE cycle proved stable.
  digit_t enc;

  led7_seg_encoder u_seg_encoder (
    .seg_i   (seg_prev),
    .digit_o (enc)
  );

  // Frame assembly, stability tracking and candidate selection
  digit_t [NUM_DIGITS-1:0] shadow_q, prev_q, last_pub_q;
  logic   [NUM_DIGITS-1:0] seen_q, seen_d;
  logic   [MatchW-1:0]     match_q, match_d;
  logic                    have_prev_q, have_pub_q;
  logic                    frame_done, cand_valid;

  assign frame_done = &seen_q;

  always_comb begin
    seen_d = seen_q;
    if (frame_done) seen_d = '0;
    if (capture) seen_d = seen_d | ~an_prev;
  end

  always_comb begin
    match_d    = match_q;
    cand_valid = 1'b0;
    if (frame_done) begin
      if (have_prev_q && (shadow_q == prev_q)) begin
        match_d = (match_q >= MatchMax) ? MatchMax : match_q + MatchW'(1);
      end else begin
        match_d = MatchW'(1);
      end
      cand_valid = (match_d == MatchMax) && (!have_pub_q || (shadow_q != last_pub_q));
    end
    if (scan_lost) match_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q    <= '0;
      prev_q      <= '0;
      last_pub_q  <= '0;
      seen_q      <= '0;
      match_q     <= '0;
      have_prev_q <= 1'b0;
      have_pub_q  <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (capture && !an_prev[i]) shadow_q[i] <= enc;
      end
      if (frame_done) begin
        prev_q      <= shadow_q;
        have_prev_q <= 1'b1;
      end
      if (cand_valid) begin
        last_pub_q <= shadow_q;
        have_pub_q <= 1'b1;
      end
      seen_q  <= seen_d;
      match_q <= match_d;
    end
  end

  // Output register with a one-deep pending slot behind it
  digit_t [NUM_DIGITS-1:0] out_q, out_d, pend_q, pend_d;
  logic                    valid_q, valid_d, pend_valid_q, pend_valid_d;
  logic                    xfer;

  assign xfer = valid_q && ready_in;

  always_comb begin
    out_d        = out_q;
    valid_d      = valid_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    if (cand_valid) begin
      if (!valid_q || xfer) begin
        out_d        = shadow_q;
        valid_d      = 1'b1;
        pend_valid_d = 1'b0;
      end else begin
        pend_d       = shadow_q;
        pend_valid_d = 1'b1;
      end
    end else if (xfer) begin
      if (pend_valid_q) begin
        out_d        = pend_q;
        pend_valid_d = 1'b0;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) out_q[i] <= DigitReset;
      pend_q       <= '0;
      valid_q      <= 1'b0;
      pend_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      pend_q       <= pend_d;
      valid_q      <= valid_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  assign valid_out = valid_q;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_out
    assign value_out[4*g +: 4] = out_q[g].nibble;
    assign blank_out[g]        = out_q[g].blank;
    assign err_out[g]          = out_q[g].err;
  end

`ifdef LED7_SCAN_TIMEOUT_EN
  logic [31:0] idle_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q <= '0;
    end else if (capture) begin
      idle_q <= '0;
    end else if (idle_q != '1) begin
      idle_q <= idle_q + 32'd1;
    end
  end

  assign scan_lost = (idle_q >= 32'(TIMEOUT_CYC));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign scan_lost      = 1'b0;
`endif

endmodule

// File: tb/tb_led7_scan_encoder.sv
// Directed bench for led7_scan_encoder: reset, frame debounce, blank/err decode,
// back-pressure with pending slot, and the scan_lost indicator.
`timescale 1ns/1ps
module tb_led7_scan_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_in;
  logic [3:0]  an_in;
  logic [15:0] value_out;
  logic [3:0]  blank_out, err_out;
  logic        valid_out, ready_in, scan_lost;

  always #5 clk = ~clk;

  led7_scan_encoder #(
    .NUM_DIGITS    (4),
    .SETTLE_CYC    (16),
    .STABLE_FRAMES (2),
    .TIMEOUT_CYC   (100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_in    (seg_in),
    .an_in     (an_in),
    .value_out (value_out),
    .blank_out (blank_out),
    .err_out   (err_out),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .scan_lost (scan_lost)
  );

`ifdef LED7_SCAN_TIMEOUT_EN
  localparam logic ExpLost = 1'b1;
`else
  localparam logic ExpLost = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transfer monitor
  logic [15:0] pub_val   [0:31];
  logic [3:0]  pub_blank [0:31];
  logic [3:0]  pub_err   [0:31];
  int          pub_n        = 0;
  int          valid_cycles = 0;

  always @(negedge clk) begin
    if (valid_out) valid_cycles <= valid_cycles + 1;
    if (valid_out && ready_in && pub_n < 32) begin
      pub_val[pub_n]   <= value_out;
      pub_blank[pub_n] <= blank_out;
      pub_err[pub_n]   <= err_out;
      pub_n            <= pub_n + 1;
    end
  end

  task automatic show(input int d, input logic [6:0] s, input int n);
    an_in    = 4'hF;
    an_in[d] = 1'b0;
    seg_in   = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    an_in  = 4'hF;
    seg_in = 7'h7F;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                       input logic [6:0] s3, input int n1);
    show(0, s0, 20);
    show(1, s1, n1);
    show(2, s2, 20);
    show(3, s3, 20);
    gap(4);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    gap(3);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  int base;
  int vstart;

  initial begin
    rst_n    = 1'b0;
    ready_in = 1'b1;
    an_in    = 4'hF;
    seg_in   = 7'h7F;
    repeat (3) @(posedge clk);
    #1;
    check("rst_value", value_out, 16'h0000);
    check("rst_blank", blank_out, 4'hF);
    check("rst_err",   err_out,   4'h0);
    check("rst_valid", valid_out, 1'b0);
    check("rst_lost",  scan_lost, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // "1234": first frame alone never publishes, second does for one cycle
    vstart = valid_cycles;
    frame(7'h79, 7'h24, 7'h30, 7'h19, 20);
    check("f1_nopub", pub_n, 0);
    frame(7'h79, 7'h24, 7'h30, 7'h19, 20);
    gap(4);
    check("f2_pubn",   pub_n, 1);
    check("f2_value",  pub_val[0], 16'h4321);
    check("f2_blank",  pub_blank[0], 4'h0);
    check("f2_err",    pub_err[0], 4'h0);
    check("f2_vcyc",   valid_cycles - vstart, 1);
    check("f2_vdrop",  valid_out, 1'b0);

    // Same frame again is not republished
    frame(7'h79, 7'h24, 7'h30, 7'h19, 20);
    check("f3_norepub", pub_n, 1);

    // Reset asserted while digit 0 is settling
    show(0, 7'h12, 8);
    rst_n = 1'b0;
    #1;
    check("mid_rst_value", value_out, 16'h0000);
    check("mid_rst_blank", blank_out, 4'hF);
    check("mid_rst_err",   err_out,   4'h0);
    check("mid_rst_valid", valid_out, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    gap(2);
    base = pub_n;
    frame(7'h79, 7'h24, 7'h30, 7'h19, 20);
    check("post_rst_f1", pub_n, base);
    frame(7'h79, 7'h24, 7'h30, 7'h19, 20);
    check("post_rst_f2", pub_n, base + 1);
    check("post_rst_val", pub_val[base], 16'h4321);

    // Settle abort: digit 1 held 10 cycles, no frame ever completes
    base = pub_n;
    frame(7'h12, 7'h02, 7'h78, 7'h00, 10);
    frame(7'h12, 7'h02, 7'h78, 7'h00, 10);
    check("abort_nopub", pub_n, base);
    check("abort_valid", valid_out, 1'b0);

    // Blank and invalid digits
    do_reset();
    base = pub_n;
    frame(7'h79, 7'h24, 7'h7F, 7'h55, 20);
    frame(7'h79, 7'h24, 7'h7F, 7'h55, 20);
    check("inv_pubn",  pub_n, base + 1);
    check("inv_value", pub_val[base], 16'h0021);
    check("inv_blank", pub_blank[base], 4'b0100);
    check("inv_err",   pub_err[base], 4'b1000);

    // Back-pressure: first frame holds, second waits in the pending slot
    do_reset();
    ready_in = 1'b0;
    base     = pub_n;
    frame(7'h79, 7'h24, 7'h30, 7'h19, 20);
    frame(7'h79, 7'h24, 7'h30, 7'h19, 20);
    check("bp_valid1", valid_out, 1'b1);
    check("bp_value1", value_out, 16'h4321);
    frame(7'h12, 7'h02, 7'h78, 7'h00, 20);
    frame(7'h12, 7'h02, 7'h78, 7'h00, 20);
    check("bp_valid2", valid_out, 1'b1);
    check("bp_value2", value_out, 16'h4321);
    check("bp_nopub",  pub_n, base);
    ready_in = 1'b1;
    @(negedge clk);
    check("bp_xfer1_value", value_out, 16'h4321);
    @(negedge clk);
    check("bp_next_value", value_out, 16'h8765);
    check("bp_next_valid", valid_out, 1'b1);
    @(negedge clk);
    check("bp_drop_valid", valid_out, 1'b0);
    #1;
    check("bp_pubn",  pub_n, base + 2);
    check("bp_pub0",  pub_val[base], 16'h4321);
    check("bp_pub1",  pub_val[base + 1], 16'h8765);
    @(posedge clk);
    #1;

    // Scan stops, then resumes with new content
    gap(110);
    check("idle_lost", scan_lost, ExpLost);
    base = pub_n;
    show(0, 7'h10, 20);
    check("resume_lost", scan_lost, 1'b0);
    show(1, 7'h08, 20);
    show(2, 7'h03, 20);
    show(3, 7'h46, 20);
    gap(4);
    check("resume_f1", pub_n, base);
    frame(7'h10, 7'h08, 7'h03, 7'h46, 20);
    check("resume_f2",  pub_n, base + 1);
    check("resume_val", pub_val[base], 16'hCBA9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
